// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: 2-entry (main + skid) elastic buffer between the ALU and memory stages.
// Optional forwarding outputs (fwd_valid/fwd_rd/fwd_data) are enabled by defining EXMEM_FWD_EN.

`ifndef WORD
`define WORD 32
`endif

module ex_mem_reg #(
    parameter int DATA_W = `WORD,
    parameter int RA_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_zero,
    input  logic [RA_W-1:0]   in_rd,
    input  logic              in_reg_write,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic [DATA_W-1:0] in_store_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic [RA_W-1:0]   out_rd,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic [DATA_W-1:0] out_store_data,
    output logic [15:0]       retire_cnt
`ifdef EXMEM_FWD_EN
   ,output logic              fwd_valid,
    output logic [RA_W-1:0]   fwd_rd,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic [RA_W-1:0]   rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic [DATA_W-1:0] store_data;
    } entry_t;

    state_t      state_q, state_d;
    entry_t      main_q, main_d;
    entry_t      skid_q, skid_d;
    logic        in_ready_q, in_ready_d;
    logic [15:0] retire_q, retire_d;

    entry_t in_entry;
    logic   accept;
    logic   drain;

    assign in_entry = '{
        result:     in_result,
        zero:       in_zero,
        rd:         in_rd,
        reg_write:  in_reg_write,
        mem_read:   in_mem_read,
        mem_write:  in_mem_write,
        store_data: in_store_data
    };

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready_q;
    assign drain     = out_valid & out_ready;

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        retire_d = retire_q;

        if (flush) begin
            state_d = EMPTY;
        end else begin
            retire_d = retire_q + 16'(drain);
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = in_entry;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        main_d = in_entry;
                    end else if (accept) begin
                        skid_d  = in_entry;
                        state_d = TWO;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a drain can move the buffer.
                    if (drain) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        in_ready_d = (state_d != TWO);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    // NOTE: both entries are reset too, so out_* read 0 during reset and nothing survives it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
            retire_q   <= '0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
            retire_q   <= retire_d;
        end
    end

    assign out_result     = main_q.result;
    assign out_zero       = main_q.zero;
    assign out_rd         = main_q.rd;
    assign out_reg_write  = main_q.reg_write;
    assign out_mem_read   = main_q.mem_read;
    assign out_mem_write  = main_q.mem_write;
    assign out_store_data = main_q.store_data;
    assign retire_cnt     = retire_q;

`ifdef EXMEM_FWD_EN
    // r0 is hard-wired zero, so writes to it are never forwarded.
    assign fwd_valid = out_valid & main_q.reg_write & (main_q.rd != '0);
    assign fwd_rd    = main_q.rd;
    assign fwd_data  = main_q.result;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed, scoreboard-checked bench for ex_mem_reg (expected entries queued on accept, compared on output).
// Forwarding outputs are checked when EXMEM_FWD_EN is defined.

module tb_ex_mem_reg;

    localparam int DATA_W = 32;
    localparam int RA_W   = 5;

    typedef struct {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic [RA_W-1:0]   rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic [DATA_W-1:0] store_data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic              in_zero;
    logic [RA_W-1:0]   in_rd;
    logic              in_reg_write;
    logic              in_mem_read;
    logic              in_mem_write;
    logic [DATA_W-1:0] in_store_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic              out_zero;
    logic [RA_W-1:0]   out_rd;
    logic              out_reg_write;
    logic              out_mem_read;
    logic              out_mem_write;
    logic [DATA_W-1:0] out_store_data;
    logic [15:0]       retire_cnt;
`ifdef EXMEM_FWD_EN
    logic              fwd_valid;
    logic [RA_W-1:0]   fwd_rd;
    logic [DATA_W-1:0] fwd_data;
`endif

    ex_mem_reg #(.DATA_W(DATA_W), .RA_W(RA_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_result      (in_result),
        .in_zero        (in_zero),
        .in_rd          (in_rd),
        .in_reg_write   (in_reg_write),
        .in_mem_read    (in_mem_read),
        .in_mem_write   (in_mem_write),
        .in_store_data  (in_store_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_zero       (out_zero),
        .out_rd         (out_rd),
        .out_reg_write  (out_reg_write),
        .out_mem_read   (out_mem_read),
        .out_mem_write  (out_mem_write),
        .out_store_data (out_store_data),
        .retire_cnt     (retire_cnt)
`ifdef EXMEM_FWD_EN
       ,.fwd_valid      (fwd_valid),
        .fwd_rd         (fwd_rd),
        .fwd_data       (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    logic        exp_ready;
    logic [15:0] exp_retire;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] res, input logic [RA_W-1:0] rd,
                         input logic rw);
        in_valid      = v;
        in_result     = res;
        in_rd         = rd;
        in_reg_write  = rw;
        in_zero       = (res == '0);
        in_mem_read   = 1'($urandom_range(0, 1));
        in_mem_write  = 1'($urandom_range(0, 1));
        in_store_data = $urandom;
    endtask

    // One clock: compare at the falling edge, then advance the model across the rising edge.
    task automatic step();
        logic acc, drn;
        exp_t e;
        @(negedge clk);
        check("in_ready", 64'(in_ready), 64'(exp_ready));
        check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        check("retire_cnt", 64'(retire_cnt), 64'(exp_retire));
        if (sb.size() != 0) begin
            e = sb[0];
            check("out_result", 64'(out_result), 64'(e.result));
            check("out_zero", 64'(out_zero), 64'(e.zero));
            check("out_rd", 64'(out_rd), 64'(e.rd));
            check("out_reg_write", 64'(out_reg_write), 64'(e.reg_write));
            check("out_mem_read", 64'(out_mem_read), 64'(e.mem_read));
            check("out_mem_write", 64'(out_mem_write), 64'(e.mem_write));
            check("out_store_data", 64'(out_store_data), 64'(e.store_data));
        end
`ifdef EXMEM_FWD_EN
        check("fwd_valid", 64'(fwd_valid),
              64'(sb.size() != 0 && sb[0].reg_write && sb[0].rd != 0));
        if (sb.size() != 0) begin
            check("fwd_rd", 64'(fwd_rd), 64'(sb[0].rd));
            check("fwd_data", 64'(fwd_data), 64'(sb[0].result));
        end
`endif
        acc = in_valid & exp_ready;
        drn = (sb.size() != 0) & out_ready;
        e = '{in_result, in_zero, in_rd, in_reg_write, in_mem_read, in_mem_write, in_store_data};
        @(posedge clk);
        if (flush) begin
            sb.delete();
        end else begin
            if (drn) void'(sb.pop_front());
            if (acc) sb.push_back(e);
            exp_retire = exp_retire + 16'(drn);
        end
        exp_ready = (sb.size() < 2);
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        sb.delete();
        exp_ready  = 1'b0;
        exp_retire = '0;
        #2;
        check("rst in_ready", 64'(in_ready), 64'd0);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_result", 64'(out_result), 64'd0);
        check("rst out_rd", 64'(out_rd), 64'd0);
        check("rst out_store_data", 64'(out_store_data), 64'd0);
        check("rst retire_cnt", 64'(retire_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst release in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        exp_ready = 1'b1;
        check("first edge in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [15:0] saved_retire;
        int          budget;

        apply_reset();

        // Single beat: visible one cycle after accept, then drained.
        out_ready = 1'b1;
        drive(1'b1, 32'h0000_0005, 5'd3, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b0);
        check("s1 out_valid", 64'(out_valid), 64'd1);
        check("s1 out_result", 64'(out_result), 64'h5);
        check("s1 out_rd", 64'(out_rd), 64'd3);
        step();
        check("s1 retire_cnt", 64'(retire_cnt), 64'd1);

        // Backpressure: fill both entries, hold, then drain in order.
        out_ready = 1'b0;
        drive(1'b1, 32'h11, 5'd1, 1'b1);
        step();
        drive(1'b1, 32'h22, 5'd2, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b0);
        check("s2 in_ready low", 64'(in_ready), 64'd0);
        check("s2 head A", 64'(out_result), 64'h11);
        step();
        step();
        check("s2 head A held", 64'(out_result), 64'h11);
        out_ready = 1'b1;
        step();
        check("s2 head B", 64'(out_result), 64'h22);
        check("s2 in_ready back", 64'(in_ready), 64'd1);
        step();
        check("s2 drained", 64'(out_valid), 64'd0);

        // ONE with simultaneous accept and drain stays ONE with the new data.
        out_ready = 1'b0;
        drive(1'b1, 32'h44, 5'd4, 1'b0);
        step();
        out_ready = 1'b1;
        drive(1'b1, 32'h33, 5'd5, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b0);
        out_ready = 1'b0;
        check("s3 out_result", 64'(out_result), 64'h33);
        check("s3 in_ready", 64'(in_ready), 64'd1);
        step();

        // TWO, then flush with an incoming beat and a drain request.
        drive(1'b1, 32'h55, 5'd6, 1'b1);
        step();
        check("s4 in TWO", 64'(in_ready), 64'd0);
        saved_retire = retire_cnt;
        flush     = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'h66, 5'd7, 1'b1);
        step();
        flush = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        check("s4 flush out_valid", 64'(out_valid), 64'd0);
        check("s4 flush in_ready", 64'(in_ready), 64'd1);
        check("s4 flush retire", 64'(retire_cnt), 64'(saved_retire));
        step();

        // Forwarding: rd 0 never forwards, rd 7 does.
        out_ready = 1'b0;
        drive(1'b1, 32'hA5A5_0000, 5'd0, 1'b1);
        step();
        drive(1'b1, 32'h1234_5678, 5'd7, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b0);
`ifdef EXMEM_FWD_EN
        check("fwd rd0 valid", 64'(fwd_valid), 64'd0);
`endif
        out_ready = 1'b1;
        step();
`ifdef EXMEM_FWD_EN
        check("fwd rd7 valid", 64'(fwd_valid), 64'd1);
        check("fwd rd7 data", 64'(fwd_data), 64'h1234_5678);
`endif
        step();

        // Reset mid-transfer discards both entries.
        out_ready = 1'b0;
        drive(1'b1, 32'h77, 5'd8, 1'b1);
        step();
        drive(1'b1, 32'h88, 5'd9, 1'b1);
        step();
        apply_reset();
        check("mid reset empty", 64'(out_valid), 64'd0);

        // Counter wrap: stream back-to-back beats until 0xFFFF, then one more drain.
        out_ready = 1'b1;
        budget    = 70000;
        while (exp_retire != 16'hFFFF && budget > 0) begin
            drive(1'b1, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            step();
            budget--;
        end
        check("wrap budget left", 64'(budget > 0), 64'd1);
        drive(1'b0, '0, '0, 1'b0);
        check("wrap at max", 64'(retire_cnt), 64'hFFFF);
        step();
        check("wrap to zero", 64'(retire_cnt), 64'h0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
